finger_identification: RTL and testbench
========================================

Name: finger_identification

Overview:
- Classifies which of the five fingers are extended in a binary hand image streamed one pixel per clock in raster order.
- The palm geometry is supplied on static inputs by the upstream palm-detection stage.
- The block counts foreground pixels in five finger zones on fixed scan rows.
- At end of frame it registers one status bit per finger for the downstream gesture decoder.

Parameters:
- IMG_W, 160, image width in pixels (columns per row).
- IMG_H, 120, image height in pixels (rows per frame).
- SCAN_OFFSET, 4, rows between palm bottom and finger scan row.
- MIN_PIX, 3, minimum foreground pixels in a zone to declare a finger extended.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- object_image  input  1  current pixel (1 = hand/foreground), sampled every rising edge.
- palm_width  input  8  palm width in pixels.
- palm_height  input  8  palm height in pixels.
- start_of_palm_r  input  8  row of palm top edge, left end.
- start_of_palm_c  input  8  column of palm left edge.
- end_of_palm_r  input  8  row of palm top edge, right end.
- end_of_palm_c  input  8  column of palm right edge (inclusive clip).
- thumb_status  output  1  1 = thumb extended.
- index_status  output  1  1 = index extended.
- middle_status  output  1  1 = middle extended.
- ring_status  output  1  1 = ring extended.
- pinky_status  output  1  1 = pinky extended.

Behaviour:
- Reset (async, rst=1):
  - row/col counters = 0, all zone counters = 0, all five status outputs = 0.
  - Reset mid-frame aborts the frame; the next sampled pixel after release is (0,0).
- Pixel stream:
  - No valid strobe; every rising edge with rst=0 consumes one pixel.
  - col increments 0..IMG_W-1, then wraps to 0 and row increments; row wraps to 0 after IMG_H-1.
- Geometry:
  - All geometry inputs are latched when pixel (0,0) is consumed and held for the whole frame.
  - ref_r = max(start_of_palm_r, end_of_palm_r).
  - zw = palm_width >> 2 (truncating).
  - Finger scan row fr = ref_r + palm_height + SCAN_OFFSET, computed at 10 bits.
  - Thumb scan row tr = ref_r + (palm_height >> 1).
- Zones:
  - Index: cols [c, c+zw-1], where c = start_of_palm_c.
  - Middle: cols [c+zw, c+2zw-1].
  - Ring: cols [c+2zw, c+3zw-1].
  - Pinky: cols [c+3zw, c+4zw-1].
  - Index, middle, ring and pinky are counted on row fr only.
  - Thumb: cols [max(0, c-zw), c-1] on row tr; the thumb zone is empty if c=0.
  - Any column > end_of_palm_c is excluded from the four finger zones.
  - zw=0 means all zones are empty.
  - fr >= IMG_H means no finger pixels are counted.
- Counting:
  - Each zone has an 8-bit saturating counter, incremented when object_image=1 and (row,col) lies in the zone.
- End of frame:
  - On the edge that consumes pixel (IMG_H-1, IMG_W-1), each status register loads (final zone count >= MIN_PIX), including that last pixel.
  - Outputs are valid the following cycle.
  - All zone counters clear on the same edge.
- Outputs are registered, hold between frame ends, and never glitch mid-frame.

Test Plan:
- Reset: assert rst asynchronously mid-frame with some pixels set -> all statuses 0 immediately; after release, the counter restarts at (0,0).
- Open hand, using palm_width=32, palm_height=39, start_r=end_r=10, start_c=78, end_c=110:
  - fr=53, zw=8; zones are index 78-85, middle 86-93, ring 94-101, pinky 102-109, thumb row 29 cols 70-77.
  - Set 4 foreground pixels in each zone -> all five statuses 1 one cycle after the last pixel of the frame.
- Threshold, same geometry:
  - 2 pixels in the index zone -> index_status 0.
  - 3 pixels in the middle zone -> middle_status 1.
  - Pixels at row 52 or 54 only -> 0.
- Clipping: end_c=100 with pixels only at cols 102-109 of row 53 -> pinky_status 0.
- Frame-to-frame hold: frame 1 is a fist (all zeros), then frame 2 has index only -> outputs stay 0 throughout frame 2 and change to index=1 only after frame 2's last pixel.
- Out-of-range: palm_height=120 -> fr >= IMG_H, so the four finger statuses are 0 regardless of image; the thumb is still evaluated.

Source files
------------

// File: rtl/finger_identification.sv
// Finger extension classifier: counts foreground pixels of a raster-streamed binary
// hand image in five palm-relative zones and registers one status bit per finger per frame.
module finger_identification #(
   parameter int unsigned IMG_W       = 160,
   parameter int unsigned IMG_H       = 120,
   parameter int unsigned SCAN_OFFSET = 4,
   parameter int unsigned MIN_PIX     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       object_image,
   input  logic [7:0] palm_width,
   input  logic [7:0] palm_height,
   input  logic [7:0] start_of_palm_r,
   input  logic [7:0] start_of_palm_c,
   input  logic [7:0] end_of_palm_r,
   input  logic [7:0] end_of_palm_c,
   output logic       thumb_status,
   output logic       index_status,
   output logic       middle_status,
   output logic       ring_status,
   output logic       pinky_status
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam int unsigned GW    = 10;
   localparam int unsigned NZ    = 5;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [GW-1:0]    fr_q, tr_q, zw_q;
   logic [7:0]       c_q, end_q;
   logic [7:0]       cnt     [NZ];
   logic [7:0]       cnt_nxt [NZ];
   logic [NZ-1:0]    status;

   logic             first, last;
   logic [7:0]       ref_r;
   logic [GW-1:0]    fr_now, tr_now, zw_now;
   logic [GW-1:0]    fr, tr, zw, c, ec, col_w, row_w;
   logic [GW-1:0]    bnd [NZ];
   logic [NZ-1:0]    hit;

   assign first  = (row == '0) && (col == '0);
   assign last   = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
   assign ref_r  = (start_of_palm_r > end_of_palm_r) ? start_of_palm_r : end_of_palm_r;
   assign fr_now = GW'(ref_r) + GW'(palm_height) + GW'(SCAN_OFFSET);
   assign tr_now = GW'(ref_r) + GW'(palm_height >> 1);
   assign zw_now = GW'(palm_width >> 2);

   // Pixel (0,0) is classified with the live geometry, every later pixel with the latched copy.
   always_comb begin
      fr    = first ? fr_now : fr_q;
      tr    = first ? tr_now : tr_q;
      zw    = first ? zw_now : zw_q;
      c     = GW'(first ? start_of_palm_c : c_q);
      ec    = GW'(first ? end_of_palm_c : end_q);
      col_w = GW'(col);
      row_w = GW'(row);
      hit   = '0;
      bnd[0] = c;
      for (int k = 0; k < NZ - 1; k++) begin
         bnd[k+1] = bnd[k] + zw;
      end
      // Thumb sits left of the palm: c-zw <= col < c, written without underflow.
      hit[0] = (row_w == tr) && (col_w < c) && ((col_w + zw) >= c);
      for (int k = 0; k < NZ - 1; k++) begin
         hit[k+1] = (row_w == fr) && (col_w >= bnd[k]) && (col_w < bnd[k+1]) && (col_w <= ec);
      end
      for (int i = 0; i < NZ; i++) begin
         cnt_nxt[i] = (object_image && hit[i] && (cnt[i] != 8'hFF)) ? cnt[i] + 8'd1 : cnt[i];
      end
   end

   // Raster position, geometry latch, zone counters and end-of-frame status load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col    <= '0;
         row    <= '0;
         fr_q   <= '0;
         tr_q   <= '0;
         zw_q   <= '0;
         c_q    <= '0;
         end_q  <= '0;
         status <= '0;
         for (int i = 0; i < NZ; i++) cnt[i] <= '0;
      end else begin
         if (col == COL_W'(IMG_W - 1)) begin
            col <= '0;
            row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
         if (first) begin
            fr_q  <= fr_now;
            tr_q  <= tr_now;
            zw_q  <= zw_now;
            c_q   <= start_of_palm_c;
            end_q <= end_of_palm_c;
         end
         for (int i = 0; i < NZ; i++) begin
            if (last) begin
               status[i] <= (cnt_nxt[i] >= 8'(MIN_PIX));
               cnt[i]    <= '0;
            end else begin
               cnt[i]    <= cnt_nxt[i];
            end
         end
      end
   end

   assign thumb_status  = status[0];
   assign index_status  = status[1];
   assign middle_status = status[2];
   assign ring_status   = status[3];
   assign pinky_status  = status[4];

endmodule

// File: tb/tb_finger_identification.sv
// Directed frame-level bench for finger_identification: one table record per frame
// (geometry, foreground runs, expected statuses) plus a mid-frame async reset sequence.
module tb_finger_identification;

   localparam int IMG_W = 160;
   localparam int IMG_H = 120;
   localparam int NPIX  = IMG_W * IMG_H;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] lo;
      logic [7:0] hi;
   } run_t;

   typedef struct packed {
      logic [7:0]     pw, ph, sr, er, sc, ec;
      logic           swap;     // revert geometry inputs to frame 0's after pixel (0,0)
      logic [4:0]     exp;      // {thumb, index, middle, ring, pinky}
      run_t [7:0]     runs;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       object_image;
   logic [7:0] palm_width, palm_height;
   logic [7:0] start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c;
   logic       thumb_status, index_status, middle_status, ring_status, pinky_status;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vecs [4];

   always #5 clk = ~clk;

   finger_identification dut (
      .clk             (clk),
      .rst             (rst),
      .object_image    (object_image),
      .palm_width      (palm_width),
      .palm_height     (palm_height),
      .start_of_palm_r (start_of_palm_r),
      .start_of_palm_c (start_of_palm_c),
      .end_of_palm_r   (end_of_palm_r),
      .end_of_palm_c   (end_of_palm_c),
      .thumb_status    (thumb_status),
      .index_status    (index_status),
      .middle_status   (middle_status),
      .ring_status     (ring_status),
      .pinky_status    (pinky_status)
   );

   function automatic logic [4:0] actual();
      return {thumb_status, index_status, middle_status, ring_status, pinky_status};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (thumb,index,middle,ring,pinky)", name, act, exp);
      end
   endtask

   function automatic logic in_image(input vec_t v, input int row, input int col);
      run_t rn;
      for (int k = 0; k < 8; k++) begin
         rn = v.runs[k];
         if (int'(rn.r) == row && col >= int'(rn.lo) && col <= int'(rn.hi)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic set_geom(input vec_t v);
      palm_width      = v.pw;
      palm_height     = v.ph;
      start_of_palm_r = v.sr;
      end_of_palm_r   = v.er;
      start_of_palm_c = v.sc;
      end_of_palm_c   = v.ec;
   endtask

   task automatic drive_pixel(input vec_t v, input int p);
      if (v.swap && p >= 1) set_geom(vecs[0]);
      else set_geom(v);
      object_image = in_image(v, p / IMG_W, p % IMG_W);
   endtask

   // Called at a falling edge; each following rising edge consumes one pixel.
   task automatic run_frame(input int f, input logic [4:0] hold);
      string tag;
      for (int p = 0; p < NPIX; p++) begin
         if (p == NPIX / 2) begin
            tag = $sformatf("frame%0d_hold_mid", f);
            check(tag, actual(), hold);
         end
         if (p == NPIX - 1) begin
            tag = $sformatf("frame%0d_hold_before_last", f);
            check(tag, actual(), hold);
         end
         drive_pixel(vecs[f], p);
         @(negedge clk);
      end
      tag = $sformatf("frame%0d_result", f);
      check(tag, actual(), vecs[f].exp);
   endtask

   function automatic vec_t blank(input logic [7:0] pw, ph, sr, er, sc, ec);
      vec_t v;
      v.pw = pw; v.ph = ph; v.sr = sr; v.er = er; v.sc = sc; v.ec = ec;
      v.swap = 1'b0;
      v.exp  = '0;
      for (int k = 0; k < 8; k++) v.runs[k] = '{8'd0, 8'd1, 8'd0};
      return v;
   endfunction

   initial begin
      logic [4:0] hold;

      // Open hand: fr=53, tr=29, zw=8; four pixels in every zone.
      vecs[0] = blank(8'd32, 8'd39, 8'd10, 8'd10, 8'd78, 8'd110);
      vecs[0].runs[0] = '{8'd29, 8'd70,  8'd73};
      vecs[0].runs[1] = '{8'd53, 8'd78,  8'd81};
      vecs[0].runs[2] = '{8'd53, 8'd86,  8'd89};
      vecs[0].runs[3] = '{8'd53, 8'd94,  8'd97};
      vecs[0].runs[4] = '{8'd53, 8'd102, 8'd105};
      vecs[0].exp = 5'b11111;

      // Thresholds and zone edges: thumb 70,71,77 (69 outside) -> 3; index 2; middle 3;
      // ring only on rows 52/54; pinky 106-109 counted, 110 past the last zone.
      vecs[1] = blank(8'd32, 8'd39, 8'd10, 8'd10, 8'd78, 8'd110);
      vecs[1].runs[0] = '{8'd29, 8'd69,  8'd71};
      vecs[1].runs[1] = '{8'd29, 8'd77,  8'd78};
      vecs[1].runs[2] = '{8'd53, 8'd78,  8'd79};
      vecs[1].runs[3] = '{8'd53, 8'd86,  8'd88};
      vecs[1].runs[4] = '{8'd52, 8'd94,  8'd97};
      vecs[1].runs[5] = '{8'd54, 8'd94,  8'd97};
      vecs[1].runs[6] = '{8'd53, 8'd106, 8'd110};
      vecs[1].exp = 5'b10101;

      // Clip at end_c=100: ring keeps 98-100 (3), pinky 102-109 dropped; ref_r = max(10,3).
      vecs[2] = blank(8'd32, 8'd39, 8'd10, 8'd3, 8'd78, 8'd100);
      vecs[2].runs[0] = '{8'd53, 8'd98, 8'd109};
      vecs[2].exp = 5'b00010;

      // palm_height=120: fr=134 out of image, tr=70; geometry inputs change after (0,0).
      vecs[3] = blank(8'd32, 8'd120, 8'd10, 8'd10, 8'd78, 8'd110);
      vecs[3].swap = 1'b1;
      vecs[3].runs[0] = '{8'd14, 8'd70, 8'd110};
      vecs[3].runs[1] = '{8'd53, 8'd70, 8'd110};
      vecs[3].runs[2] = '{8'd70, 8'd70, 8'd72};
      vecs[3].runs[3] = '{8'd29, 8'd70, 8'd77};
      vecs[3].exp = 5'b10000;

      rst = 1'b1;
      object_image = 1'b0;
      set_geom(vecs[0]);
      repeat (3) @(negedge clk);
      check("reset_state", actual(), 5'b00000);
      rst = 1'b0;

      run_frame(0, 5'b00000);

      // Abort a frame with an asynchronous reset between clock edges.
      for (int p = 0; p < 60; p++) begin
         drive_pixel(vecs[1], p);
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1 check("async_reset_mid_frame", actual(), 5'b00000);
      @(negedge clk);
      rst = 1'b0;

      hold = 5'b00000;
      for (int f = 1; f < 4; f++) begin
         run_frame(f, hold);
         hold = vecs[f].exp;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
